// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse transmitter:
//   - state_t        : transmitter FSM states
//   - WORD_GAP_UNITS : gap length (units) used after the last character of a word
//   - CH_A .. CH_9   : character codes accepted by morse_lut (A-Z = 0-25, 0-9 = 26-35)
//   - max2()         : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        GAP
    } state_t;

    localparam int WORD_GAP_UNITS = 7;

    localparam logic [5:0] CH_A = 6'd0,  CH_B = 6'd1,  CH_C = 6'd2,  CH_D = 6'd3;
    localparam logic [5:0] CH_E = 6'd4,  CH_F = 6'd5,  CH_G = 6'd6,  CH_H = 6'd7;
    localparam logic [5:0] CH_I = 6'd8,  CH_J = 6'd9,  CH_K = 6'd10, CH_L = 6'd11;
    localparam logic [5:0] CH_M = 6'd12, CH_N = 6'd13, CH_O = 6'd14, CH_P = 6'd15;
    localparam logic [5:0] CH_Q = 6'd16, CH_R = 6'd17, CH_S = 6'd18, CH_T = 6'd19;
    localparam logic [5:0] CH_U = 6'd20, CH_V = 6'd21, CH_W = 6'd22, CH_X = 6'd23;
    localparam logic [5:0] CH_Y = 6'd24, CH_Z = 6'd25;
    localparam logic [5:0] CH_0 = 6'd26, CH_1 = 6'd27, CH_2 = 6'd28, CH_3 = 6'd29;
    localparam logic [5:0] CH_4 = 6'd30, CH_5 = 6'd31, CH_6 = 6'd32, CH_7 = 6'd33;
    localparam logic [5:0] CH_8 = 6'd34, CH_9 = 6'd35;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/morse_lut.sv
// -----------------------------------------------------------------------------
// morse_lut
// Combinational character ROM: char_code -> (symbol count, symbol bits).
// Bits are right-aligned: the first symbol sent is bits_o[len_o-1], 1 = dash.
// Codes outside A-Z / 0-9 return length 0 (word space).
// Ports:
//   char_code_i  in   6        character code (CH_A..CH_9)
//   len_o        out  LW       number of symbols
//   bits_o       out  MAX_SYM  symbol pattern, 1 = dash
// -----------------------------------------------------------------------------
module morse_lut
    import morse_pkg::*;
#(
    parameter  int MAX_SYM = 6,
    localparam int LW      = $clog2(MAX_SYM + 1)
) (
    input  logic [5:0]         char_code_i,
    output logic [LW-1:0]      len_o,
    output logic [MAX_SYM-1:0] bits_o
);

    // entry = {len[2:0], bits[4:0]}; every letter/digit fits in 5 symbols
    logic [7:0] entry;

    always_comb begin
        entry = 8'd0;
        case (char_code_i)
            CH_A: entry = {3'd2, 5'b00001};
            CH_B: entry = {3'd4, 5'b01000};
            CH_C: entry = {3'd4, 5'b01010};
            CH_D: entry = {3'd3, 5'b00100};
            CH_E: entry = {3'd1, 5'b00000};
            CH_F: entry = {3'd4, 5'b00010};
            CH_G: entry = {3'd3, 5'b00110};
            CH_H: entry = {3'd4, 5'b00000};
            CH_I: entry = {3'd2, 5'b00000};
            CH_J: entry = {3'd4, 5'b00111};
            CH_K: entry = {3'd3, 5'b00101};
            CH_L: entry = {3'd4, 5'b00100};
            CH_M: entry = {3'd2, 5'b00011};
            CH_N: entry = {3'd2, 5'b00010};
            CH_O: entry = {3'd3, 5'b00111};
            CH_P: entry = {3'd4, 5'b00110};
            CH_Q: entry = {3'd4, 5'b01101};
            CH_R: entry = {3'd3, 5'b00010};
            CH_S: entry = {3'd3, 5'b00000};
            CH_T: entry = {3'd1, 5'b00001};
            CH_U: entry = {3'd3, 5'b00001};
            CH_V: entry = {3'd4, 5'b00001};
            CH_W: entry = {3'd3, 5'b00011};
            CH_X: entry = {3'd4, 5'b01001};
            CH_Y: entry = {3'd4, 5'b01011};
            CH_Z: entry = {3'd4, 5'b01100};
            CH_0: entry = {3'd5, 5'b11111};
            CH_1: entry = {3'd5, 5'b01111};
            CH_2: entry = {3'd5, 5'b00111};
            CH_3: entry = {3'd5, 5'b00011};
            CH_4: entry = {3'd5, 5'b00001};
            CH_5: entry = {3'd5, 5'b00000};
            CH_6: entry = {3'd5, 5'b10000};
            CH_7: entry = {3'd5, 5'b11000};
            CH_8: entry = {3'd5, 5'b11100};
            CH_9: entry = {3'd5, 5'b11110};
            default: entry = 8'd0;
        endcase
    end

    assign len_o  = LW'(entry[7:5]);
    assign bits_o = MAX_SYM'(entry[4:0]);

endmodule

// File: rtl/morse_tx.sv
// -----------------------------------------------------------------------------
// morse_tx
// Morse transmitter: sends one character per accepted start pulse on a single
// on/off output with standard unit timing (dot = 1 unit, dash = DASH_UNITS,
// intra-character space = 1 unit, trailing gap = CHAR_GAP_UNITS).
// Optional build macro MORSE_TX_WORD_GAP_EN: when defined, a character started
// with word_end=1 ends with a 7-unit word gap instead of CHAR_GAP_UNITS.
// Ports:
//   clk        in   1        system clock (rising edge)
//   reset_n    in   1        asynchronous active-low reset
//   start      in   1        send request, accepted only while busy=0
//   use_lut    in   1        1: encode char_code via morse_lut, 0: raw sym_len/sym_bits
//   char_code  in   6        A-Z = 0-25, 0-9 = 26-35, anything else = space
//   sym_len    in   LW       raw symbol count (clamped to MAX_SYM)
//   sym_bits   in   MAX_SYM  raw symbols, 1 = dash, first = sym_bits[sym_len-1]
//   word_end   in   1        latched with start, selects word gap (macro only)
//   tx         out  1        Morse output, 1 = mark
//   busy       out  1        character in progress
//   done       out  1        single-cycle pulse in the last busy cycle
// -----------------------------------------------------------------------------
module morse_tx
    import morse_pkg::*;
#(
    parameter  int TICK_DIV       = 25000000,
    parameter  int MAX_SYM        = 6,
    parameter  int DASH_UNITS     = 3,
    parameter  int CHAR_GAP_UNITS = 3,
    localparam int LW             = $clog2(MAX_SYM + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               use_lut,
    input  logic [5:0]         char_code,
    input  logic [LW-1:0]      sym_len,
    input  logic [MAX_SYM-1:0] sym_bits,
    input  logic               word_end,
    output logic               tx,
    output logic               busy,
    output logic               done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int UW = $clog2(max2(DASH_UNITS, WORD_GAP_UNITS) + 1);

    state_t             state_q, state_d;
    logic [PW-1:0]      pre_q,   pre_d;
    logic [UW-1:0]      unit_q,  unit_d;
    logic [LW-1:0]      idx_q,   idx_d;
    logic [MAX_SYM-1:0] bits_q,  bits_d;
    logic               tx_q,    tx_d;
    logic               busy_q,  busy_d;

    logic [LW-1:0]      lut_len;
    logic [MAX_SYM-1:0] lut_bits;
    logic [LW-1:0]      raw_len;
    logic [LW-1:0]      in_len;
    logic [MAX_SYM-1:0] in_bits;
    logic               tick;
    logic               seg_end;
    int unsigned        dur_units;
    int unsigned        gap_units;

    morse_lut #(
        .MAX_SYM (MAX_SYM)
    ) u_lut (
        .char_code_i (char_code),
        .len_o       (lut_len),
        .bits_o      (lut_bits)
    );

    assign raw_len = (sym_len > LW'(MAX_SYM)) ? LW'(MAX_SYM) : sym_len;
    assign in_len  = use_lut ? lut_len  : raw_len;
    assign in_bits = use_lut ? lut_bits : sym_bits;

`ifdef MORSE_TX_WORD_GAP_EN
    logic word_q, word_d;
    assign gap_units = word_q ? WORD_GAP_UNITS : CHAR_GAP_UNITS;
`else
    logic unused_word_end;
    assign unused_word_end = word_end;
    assign gap_units       = CHAR_GAP_UNITS;
`endif

    // The prescaler is held at 0 in IDLE, so every state starts on a unit boundary
    assign tick = (pre_q == PW'(TICK_DIV - 1));

    // Length of the current state in units
    always_comb begin
        dur_units = 1;
        case (state_q)
            MARK:    dur_units = bits_q[idx_q] ? DASH_UNITS : 1;
            SPACE:   dur_units = 1;
            GAP:     dur_units = gap_units;
            default: dur_units = 1;
        endcase
    end

    assign seg_end = tick && (32'(unit_q) == dur_units - 1);

    always_comb begin
        state_d = state_q;
        pre_d   = '0;
        unit_d  = unit_q;
        idx_d   = idx_q;
        bits_d  = bits_q;
`ifdef MORSE_TX_WORD_GAP_EN
        word_d  = word_q;
`endif

        if (state_q != IDLE) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
        if (tick) begin
            unit_d = seg_end ? '0 : unit_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    bits_d = in_bits;
                    unit_d = '0;
`ifdef MORSE_TX_WORD_GAP_EN
                    word_d = word_end;
`endif
                    if (in_len != '0) begin
                        state_d = MARK;
                        idx_d   = in_len - 1'b1;
                    end else begin
                        // space character: gap only
                        state_d = GAP;
                    end
                end
            end
            MARK: begin
                if (seg_end) begin
                    if (idx_q == '0) begin
                        state_d = GAP;
                    end else begin
                        state_d = SPACE;
                        idx_d   = idx_q - 1'b1;
                    end
                end
            end
            SPACE: begin
                if (seg_end) begin
                    state_d = MARK;
                end
            end
            GAP: begin
                if (seg_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        tx_d   = (state_d == MARK);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            unit_q  <= '0;
            idx_q   <= '0;
            bits_q  <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MORSE_TX_WORD_GAP_EN
            word_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            unit_q  <= unit_d;
            idx_q   <= idx_d;
            bits_q  <= bits_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef MORSE_TX_WORD_GAP_EN
            word_q  <= word_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    // Decoded from registered state: high in the last cycle of GAP, while busy is still 1
    assign done = (state_q == GAP) && seg_end;

endmodule
